// File: rtl/ram_loader_pkg.sv
// Shared definitions for the RAM write-side loader: state encoding and
// the default RAM geometry shared with the RAM and the read-side counter.
package ram_loader_pkg;

    localparam int AW_DEF = 4;
    localparam int DW_DEF = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        FLUSH = 2'd2
    } state_t;

endpackage

// File: rtl/wr_addr_gen.sv
// Loadable wrapping write-address counter paired with a down-counter of
// words still to be accepted in the current burst.
module wr_addr_gen #(
    parameter int AW = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          load,
    input  logic [AW-1:0] base,
    input  logic [AW:0]   len,
    input  logic          step,
    output logic [AW-1:0] addr,
    output logic          last
);

    localparam logic [AW:0] FULL = {1'b1, {AW{1'b0}}};
    localparam logic [AW:0] ONE  = {{AW{1'b0}}, 1'b1};

    logic [AW:0] remaining_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr          <= '0;
            remaining_reg <= '0;
        end else if (load) begin
            addr          <= base;
            remaining_reg <= (len > FULL) ? FULL : len;
        end else if (step) begin
            // Natural AW-bit overflow gives the wrap back to address 0.
            addr          <= addr + 1'b1;
            remaining_reg <= remaining_reg - ONE;
        end
    end

    assign last = (remaining_reg == ONE);

endmodule

// File: rtl/ram_loader.sv
// Write-side sequencer: takes a valid/ready burst of words and writes them
// to consecutive RAM addresses starting at a programmed base address.
module ram_loader
    import ram_loader_pkg::*;
#(
    parameter int AW = AW_DEF,
    parameter int DW = DW_DEF
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic [AW-1:0] base_addr,
    input  logic [AW:0]   len,
    input  logic          abort,
    input  logic          in_valid,
    input  logic [DW-1:0] in_data,
    output logic          in_ready,
    output logic          wr_en,
    output logic [AW-1:0] wr_addr,
    output logic [DW-1:0] wr_data,
    output logic          busy,
    output logic          done
);

    state_t        state_reg;
    logic          load;
    logic          xfer;
    logic          last;
    logic [AW-1:0] addr_q;

    assign in_ready = (state_reg == LOAD) && !abort;
    assign busy     = (state_reg == LOAD);
    assign xfer     = in_valid && in_ready;
    assign load     = (state_reg == IDLE) && start;

    wr_addr_gen #(.AW(AW)) u_addr_gen (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (load),
        .base  (base_addr),
        .len   (len),
        .step  (xfer),
        .addr  (addr_q),
        .last  (last)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            wr_en     <= 1'b0;
            wr_addr   <= '0;
            wr_data   <= '0;
            done      <= 1'b0;
        end else begin
            wr_en <= 1'b0;
            done  <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        // A zero-length burst completes without leaving IDLE.
                        if (len == '0) done <= 1'b1;
                        else           state_reg <= LOAD;
                    end
                end
                LOAD: begin
                    if (xfer) begin
                        wr_en   <= 1'b1;
                        wr_addr <= addr_q;
                        wr_data <= in_data;
                        if (last) begin
                            done      <= 1'b1;
                            state_reg <= FLUSH;
                        end
                    end else if (abort) begin
                        state_reg <= IDLE;
                    end
                end
                FLUSH:   state_reg <= IDLE;
                default: state_reg <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ram_loader.sv
// Directed, table-driven bench for ram_loader with a write monitor and a
// small RAM model fed from the write port.
module tb_ram_loader;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic [3:0] base_addr = '0;
    logic [4:0] len = '0;
    logic       abort = 1'b0;
    logic       in_valid = 1'b0;
    logic [3:0] in_data = '0;
    logic       in_ready;
    logic       wr_en;
    logic [3:0] wr_addr;
    logic [3:0] wr_data;
    logic       busy;
    logic       done;

    ram_loader #(.AW(4), .DW(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .base_addr (base_addr),
        .len       (len),
        .abort     (abort),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: collects writes, counts done pulses, checks wr_en against the
    // transfer observed one cycle earlier.
    typedef struct { logic [3:0] a; logic [3:0] d; } wr_t;
    wr_t        wq[$];
    int         done_cnt = 0;
    int         wr_bad = 0;
    bit         busy_seen = 0;
    logic       xfer_pend = 1'b0;
    logic [3:0] mem [16];

    always @(negedge clk) begin
        if (rst_n) begin
            if (wr_en !== xfer_pend) wr_bad++;
            if (wr_en === 1'b1) begin
                wq.push_back('{a: wr_addr, d: wr_data});
                mem[wr_addr] = wr_data;
            end
            if (done === 1'b1) done_cnt++;
            if (busy === 1'b1) busy_seen = 1;
        end
        #1;
        xfer_pend = rst_n && in_valid && in_ready;
    end

    typedef struct {
        string      name;
        logic [3:0] base;
        logic [4:0] len;
        logic [3:0] seed;
        logic [15:0] vpat;
        int         abort_after;
        bit         mid_start;
        int         exp_writes;
        int         exp_done;
        logic [3:0] exp_last;
    } vec_t;

    vec_t vecs[6];

    task automatic run_burst(input vec_t v);
        int   sent;
        int   cyc;
        int   target;
        bit   aborted;
        logic [3:0] ea;
        logic [3:0] ed;
        wq.delete();
        done_cnt  = 0;
        wr_bad    = 0;
        busy_seen = 0;
        target    = (v.len > 5'd16) ? 16 : int'(v.len);
        @(negedge clk);
        start = 1'b1; base_addr = v.base; len = v.len;
        @(negedge clk);
        start = 1'b0;
        sent = 0; cyc = 0; aborted = 0;
        while (sent < target && cyc < 40 && !aborted) begin
            start = v.mid_start && (cyc == 1);
            base_addr = 4'd8; len = 5'd2;
            if (v.abort_after >= 0 && sent == v.abort_after) begin
                abort = 1'b1; in_valid = 1'b1; aborted = 1;
            end else begin
                in_valid = v.vpat[cyc % 16];
                in_data  = v.seed + 4'(sent);
            end
            #1;
            if (in_valid && in_ready) sent++;
            @(negedge clk);
            cyc++;
        end
        start = 1'b0; abort = 1'b0; in_valid = 1'b0;
        if (cyc >= 40) begin
            fails++; tests++;
            $display("FAIL %s timeout: sent %0d of %0d", v.name, sent, target);
        end
        repeat (3) @(negedge clk);
        chk({v.name, " writes"}, wq.size(), v.exp_writes);
        for (int k = 0; k < wq.size() && k < v.exp_writes; k++) begin
            ea = v.base + 4'(k);
            ed = v.seed + 4'(k);
            chk({v.name, " addr"}, wq[k].a, ea);
            chk({v.name, " data"}, wq[k].d, ed);
        end
        if (wq.size() > 0) chk({v.name, " last_addr"}, wq[wq.size()-1].a, v.exp_last);
        chk({v.name, " done"}, done_cnt, v.exp_done);
        chk({v.name, " wr_en_timing"}, wr_bad, 0);
        chk({v.name, " busy_seen"}, busy_seen, (v.len != 0));
        chk({v.name, " idle"}, {busy, in_ready}, 2'b00);
        $display("[TB] %s: base=%0d len=%0d writes=%0d done=%0d", v.name, v.base, v.len, wq.size(), done_cnt);
    endtask

    initial begin
        vecs[0] = '{"basic",  4'd2,  5'd4,  4'hA, 16'hFFFF, -1, 1'b0, 4,  1, 4'd5};
        vecs[1] = '{"wrap",   4'd14, 5'd4,  4'h3, 16'hFFFF, -1, 1'b0, 4,  1, 4'd1};
        vecs[2] = '{"stall",  4'd7,  5'd3,  4'h5, 16'h0029, -1, 1'b0, 3,  1, 4'd9};
        vecs[3] = '{"len0",   4'd4,  5'd0,  4'h0, 16'hFFFF, -1, 1'b0, 0,  1, 4'd0};
        vecs[4] = '{"len20",  4'd9,  5'd20, 4'h0, 16'hFFFF, -1, 1'b0, 16, 1, 4'd8};
        vecs[5] = '{"abort",  4'd0,  5'd5,  4'h1, 16'hFFFF, 2,  1'b1, 2,  0, 4'd1};

        for (int i = 0; i < 16; i++) mem[i] = 4'h0;

        #2;
        chk("rst wr_en", wr_en, 0);
        chk("rst wr_addr", wr_addr, 0);
        chk("rst wr_data", wr_data, 0);
        chk("rst busy", busy, 0);
        chk("rst done", done, 0);
        chk("rst in_ready", in_ready, 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 6; i++) begin
            run_burst(vecs[i]);
            if (i == 0) begin
                for (int k = 0; k < 4; k++) chk("ram readback", mem[2+k], 4'hA + 4'(k));
            end
        end

        // Reset during the third word of a burst.
        @(negedge clk);
        start = 1'b1; base_addr = 4'd3; len = 5'd6;
        @(negedge clk);
        start = 1'b0;
        in_valid = 1'b1; in_data = 4'h1;
        @(negedge clk);
        in_data = 4'h2;
        @(negedge clk);
        in_data = 4'h3;
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst wr_en", wr_en, 0);
        chk("midrst wr_addr", wr_addr, 0);
        chk("midrst wr_data", wr_data, 0);
        chk("midrst busy", busy, 0);
        chk("midrst done", done, 0);
        chk("midrst in_ready", in_ready, 0);
        chk("midrst ram kept", mem[4], 4'h2);
        $display("[TB] midrst: outputs cleared, busy=%0b wr_en=%0b", busy, wr_en);
        in_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        chk("postrst wr_en", wr_en, 0);
        chk("postrst busy", busy, 0);
        run_burst(vecs[0]);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/ram_loader.md
# ram_loader

Write-side sequencer for the 16x4 dual-port RAM. It accepts a burst of data words over a valid/ready stream and writes them into consecutive RAM locations, starting at a programmed base address. It drives the RAM write port (`wr_addr`, `wr_en`, `wr_data`), while the free-running counter and the ROM decoder keep consuming the read port. It replaces manual driving of `adr`/`wen`/`din` from the top level.

## Interface
- `AW`, default 4: RAM address width (depth 2^AW).
- `DW`, default 4: RAM data width.

Ports:
- `clk`  in  1  system clock. All logic is rising-edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `start`  in  1  one-cycle request to begin a burst. Sampled only in IDLE.
- `base_addr`  in  AW  first write address, captured on accepted `start`.
- `len`  in  AW+1  number of words in the burst, captured on accepted `start`. Values above 2^AW are clamped to 2^AW.
- `abort`  in  1  terminates a burst in LOAD.
- `in_valid`  in  1  stream word valid.
- `in_data`  in  DW  stream word.
- `in_ready`  out  1  loader can accept a word.
- `wr_en`  out  1  RAM write enable, registered.
- `wr_addr`  out  AW  RAM write address, registered.
- `wr_data`  out  DW  RAM write data, registered.
- `busy`  out  1  high in LOAD.
- `done`  out  1  one-cycle pulse on burst completion.

## Operation
- FSM states: IDLE, LOAD, FLUSH.
- **IDLE.** On `start`:
  - Capture `base_addr` into `addr_q`.
  - Capture `min(len, 2^AW)` into `remaining`.
  - If the captured length is 0, pulse `done` next cycle and stay in IDLE.
  - Otherwise go to LOAD.
- **LOAD.** `in_ready = (state==LOAD) & ~abort`, combinational.
  - Transfer occurs when `in_valid & in_ready`. On a transfer:
    - Next cycle: `wr_en`=1, `wr_addr`=`addr_q`, `wr_data`=`in_data`.
    - `addr_q` increments modulo 2^AW, so it wraps 15→0 at AW=4.
    - `remaining` decrements.
  - On the transfer with `remaining`==1, go to FLUSH.
  - On `abort` with no transfer, go to IDLE. No `done`; the write of any previously accepted word still completes.
- **FLUSH.** Lasts exactly one cycle. The last write is on the port and `done`=1. Next state is IDLE.
- `start` in LOAD or FLUSH is ignored.
- `abort` in IDLE or FLUSH is ignored.
- `busy` = (state==LOAD).
- `wr_en` is 0 in every cycle not following a transfer, so stalls (`in_valid`=0) produce no writes.
- A length of 2^AW writes every location exactly once, starting at `base_addr`.

## Timing
- Reset values (asynchronous, when `rst_n`=0):
  - state IDLE.
  - `in_ready`, `wr_en`, `busy`, `done` all 0.
  - `wr_addr` 0, `wr_data` 0.
  - `addr_q` 0, `remaining` 0.
- Latency from a stream transfer to the RAM write is 1 cycle. Data is written at the following clock edge, and is readable by the RAM read port from the edge after that.
- Throughput is one word per cycle with `in_valid` held high. An N-word burst completes N+1 cycles after LOAD entry, with no stalls.
- `done` is asserted in the same cycle as the final `wr_en`.
- Minimum `start`-to-`start` spacing is N+2 cycles.
- Reset asserted mid-burst clears everything immediately. The RAM retains words already written, and no spurious `wr_en` occurs during or after reset.

## Structure
- Shared package holds:
  - the state encoding (IDLE=2'd0, LOAD=2'd1, FLUSH=2'd2);
  - default `AW`/`DW` constants, shared with the RAM and counter.
- One natural sub-module, `wr_addr_gen`: a loadable, enabled, wrapping AW-bit address counter paired with the `remaining` down-counter. It has ports load/base/len/step/last.
- The FSM and output registers stay in `ram_loader`.
- The top level instantiates `ram_loader` in front of the RAM write port.

## Test plan
- **Basic burst.** Reset, then `start` with `base_addr`=2, `len`=4, stream 0xA,0xB,0xC,0xD back-to-back. Required: writes to addresses 2,3,4,5 on consecutive cycles. `done` pulses with the address-5 write. The read-side counter later returns A,B,C,D at addresses 2–5.
- **Wrap-around.** `base_addr`=14, `len`=4. Required: writes to 14,15,0,1.
- **Stalls.** `len`=3, `in_valid` toggled 1,0,0,1,0,1. Required: exactly 3 `wr_en` pulses, none during stall cycles, and `busy` stays high until the last transfer.
- **Edge lengths.**
  - `len`=0: `done` the next cycle, no writes, `busy` never rises.
  - `len`=20: clamped to 16 writes covering all addresses once.
- **Abort and ignored start.** `abort` after 2 of 5 words. Required: exactly 2 writes, no `done`, return to IDLE. A `start` issued mid-burst has no effect.
- **Reset mid-burst.** Drop `rst_n` during the third word. Required: all outputs go to 0 asynchronously and state is IDLE. A new burst after reset behaves as in the basic burst case.
